afe_tx_burst_ctrl: RTL and testbench
====================================

Name: afe_tx_burst_ctrl

Overview:
- Burst sequencer between the host TX sample FIFO and the afe block's TX FIFO port (tx_fifo_req / tx_fifo_data / tx_fifo_empty), running in the tx_sclk_2x domain.
- Gates sample flow into the AFE per burst: prefill wait, fixed-length or continuous run, zero-insertion on underrun, drain tail.
- Drives AFE TX enable and reports status.

Parameters:
- FIFO_AW, 9, width of host FIFO used-words input.
- PREFILL_LVL, 64, minimum host FIFO words before a burst starts.
- DRAIN_CYC, 16, tx_sclk_2x cycles of zero samples after the last word before tx_en drops.

Ports:
- tx_sclk_2x  in  1  clock, 80 MHz sample-pair-2x clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: begin burst
- stop  in  1  one-cycle pulse: abort burst, go to drain
- cfg_burst_len  in  16  words (I/Q pairs) per burst; 0 = continuous until stop
- host_fifo_empty  in  1  host FIFO empty
- host_fifo_usedw  in  FIFO_AW  host FIFO fill level
- host_fifo_data  in  32  host FIFO read data, valid cycle after host_fifo_req
- host_fifo_req  out  1  host FIFO read request
- afe_fifo_req  in  1  word request from afe TX serializer
- afe_fifo_data  out  32  word to afe, valid cycle after afe_fifo_req
- afe_fifo_empty  out  1  empty indication to afe
- tx_en  out  1  AFE TX enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on DRAIN→IDLE
- underrun_cnt  out  16  saturating count of zero-filled words since start

Behaviour:
- Single clock, tx_sclk_2x; reset synchronous active-low. On reset_n=0 at a clock edge: state=IDLE; tx_en=0, busy=0, done=0, host_fifo_req=0, afe_fifo_empty=1, afe_fifo_data=0, underrun_cnt=0, word and drain counters 0.
- States:
  - IDLE: start → PREFILL; latch cfg_burst_len into remaining; clear underrun_cnt. Ignore start in other states.
  - PREFILL: tx_en=1, afe_fifo_empty=0, afe receives zeros. → RUN when host_fifo_usedw >= PREFILL_LVL, or when burst_len≠0 and usedw >= burst_len. stop → DRAIN.
  - RUN: host_fifo_req = afe_fifo_req & ~host_fifo_empty & (continuous | remaining≠0); combinational, same cycle as afe_fifo_req.
  - DRAIN: zeros to afe for DRAIN_CYC cycles, then → IDLE, tx_en=0, afe_fifo_empty=1, done pulse.
- RUN, each afe_fifo_req:
  - Host word read: remaining decrements; afe_fifo_data is host_fifo_data on the next cycle.
  - Host FIFO empty: underrun. Afe gets 32'h0 next cycle; underrun_cnt increments, saturating at 16'hFFFF. remaining does not decrement.
- Word order is preserved; no word is dropped or duplicated.
- afe_fifo_data holds 0 on cycles following no request.
- RUN→DRAIN: remaining reaches 0 (fixed length), or stop (any length).
- Stop in the same cycle as the final read: the read completes, then DRAIN. No extra word.
- Stop in DRAIN or IDLE: no effect.
- Start and stop in the same cycle in IDLE: start wins. Stop is evaluated from PREFILL onward.
- Reset mid-burst returns to IDLE on the next edge. An in-flight host word is discarded.
- busy = (state≠IDLE).

Optional Feature:
- Macro: AFE_TX_TEST_TONE_EN.
- Defined:
  - Adds input cfg_test (1 bit), sampled at start.
  - When set, RUN never reads the host FIFO and PREFILL exits immediately.
  - Each afe_fifo_req yields {ramp[15:0], ~ramp[15:0]} on the next cycle. ramp is 16-bit, starts at 0 each burst, increments per word and wraps 16'hFFFF→0.
  - remaining counts test words. underrun_cnt stays 0.
- Undefined: no cfg_test port; the data source is always the host FIFO.

Test Plan:
- Fixed burst: len=100, usedw=128 preloaded with words 0..127, afe_fifo_req every 2nd cycle → exactly 100 host_fifo_req; afe sees 0..99 in order, then 16 zero cycles; tx_en falls; done pulses once; underrun_cnt=0.
- Prefill: len=0, usedw rises 0→70 over time → stays in PREFILL with zeros to afe until usedw=64; first host_fifo_req on the next afe_fifo_req after that.
- Underrun: continuous burst; host FIFO empty for 5 requests mid-run → afe gets 5 zero words; underrun_cnt=5; then data resumes in order; stop → DRAIN then IDLE.
- Stop on final read: len=10, stop coincident with 10th read → 10 words delivered, DRAIN, single done pulse; no 11th host_fifo_req.
- Reset mid-RUN: reset_n low one cycle at word 37 → next edge: tx_en=0, busy=0, afe_fifo_empty=1, underrun_cnt=0; a new start runs normally.
- AFE_TX_TEST_TONE_EN: cfg_test=1, len=3 → afe words 32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD; host_fifo_req never asserts.

Source files
------------

// File: rtl/afe_tx_burst_ctrl.sv
// Burst sequencer feeding the AFE TX FIFO port from the host TX FIFO (prefill, run, underrun zero-fill, drain).
// Optional test-tone source enabled by defining AFE_TX_TEST_TONE_EN (adds cfg_test input).
module afe_tx_burst_ctrl #(
  parameter int FIFO_AW     = 9,
  parameter int PREFILL_LVL = 64,
  parameter int DRAIN_CYC   = 16
) (
  input  logic               tx_sclk_2x,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        cfg_burst_len,
`ifdef AFE_TX_TEST_TONE_EN
  input  logic               cfg_test,
`endif
  input  logic               host_fifo_empty,
  input  logic [FIFO_AW-1:0] host_fifo_usedw,
  input  logic [31:0]        host_fifo_data,
  output logic               host_fifo_req,
  input  logic               afe_fifo_req,
  output logic [31:0]        afe_fifo_data,
  output logic               afe_fifo_empty,
  output logic               tx_en,
  output logic               busy,
  output logic               done,
  output logic [15:0]        underrun_cnt,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE, PREFILL, RUN, DRAIN} state_t;

  state_t      state;
  logic [15:0] remaining;
  logic        cont;
  logic [15:0] drain_cnt;
  logic        rd_q;
  logic [31:0] fill_q;
  logic        test_mode;
  logic        want;
  logic        take;
  logic        urun;
  logic        prefill_ok;
  logic [15:0] usedw_ext;

`ifdef AFE_TX_TEST_TONE_EN
  logic        test_q;
  logic [15:0] ramp;
  assign test_mode = test_q;
`else
  assign test_mode = 1'b0;
`endif

  // Handshake: afe_fifo_req in cycle N is answered by afe_fifo_data in cycle N+1; host_fifo_req in
  // cycle N is answered by host_fifo_data in cycle N+1, so a host word passes straight through.
  assign want          = (state == RUN) && afe_fifo_req && (cont || remaining != 16'd0);
  assign take          = want && (test_mode || !host_fifo_empty);
  assign urun          = want && !test_mode && host_fifo_empty;
  assign host_fifo_req = want && !test_mode && !host_fifo_empty;

  assign usedw_ext  = 16'(host_fifo_usedw);
  assign prefill_ok = test_mode || (usedw_ext >= 16'(PREFILL_LVL)) ||
                      (!cont && usedw_ext >= remaining);

  assign afe_fifo_data = rd_q ? host_fifo_data : fill_q;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge tx_sclk_2x) begin
    if (!reset_n) begin
      state          <= IDLE;
      remaining      <= 16'd0;
      cont           <= 1'b0;
      drain_cnt      <= 16'd0;
      rd_q           <= 1'b0;
      fill_q         <= 32'd0;
      underrun_cnt   <= 16'd0;
      tx_en          <= 1'b0;
      afe_fifo_empty <= 1'b1;
      done           <= 1'b0;
`ifdef AFE_TX_TEST_TONE_EN
      test_q         <= 1'b0;
      ramp           <= 16'd0;
`endif
    end else begin
      rd_q   <= host_fifo_req;
      fill_q <= 32'd0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= PREFILL;
            remaining      <= cfg_burst_len;
            cont           <= (cfg_burst_len == 16'd0);
            underrun_cnt   <= 16'd0;
            tx_en          <= 1'b1;
            afe_fifo_empty <= 1'b0;
`ifdef AFE_TX_TEST_TONE_EN
            test_q         <= cfg_test;
            ramp           <= 16'd0;
`endif
          end
        end
        PREFILL: begin
          if (stop) begin
            state     <= DRAIN;
            drain_cnt <= 16'd0;
          end else if (prefill_ok) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (take && !cont) remaining <= remaining - 16'd1;
          if (urun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`ifdef AFE_TX_TEST_TONE_EN
          if (take && test_mode) begin
            fill_q <= {ramp, ~ramp};
            ramp   <= ramp + 16'd1;
          end
`endif
          // A read taken alongside stop still completes; its word appears in the first DRAIN cycle.
          if (stop || (take && !cont && remaining == 16'd1)) begin
            state     <= DRAIN;
            drain_cnt <= 16'd0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 16'(DRAIN_CYC - 1)) begin
            state          <= IDLE;
            drain_cnt      <= 16'd0;
            tx_en          <= 1'b0;
            afe_fifo_empty <= 1'b1;
            done           <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_tx_burst_ctrl.sv
// Bench for afe_tx_burst_ctrl: host FIFO responder, burst-level reference model, per-cycle compare.
module tb_afe_tx_burst_ctrl;
  localparam int FIFO_AW     = 9;
  localparam int PREFILL_LVL = 64;
  localparam int DRAIN_CYC   = 16;
`ifdef AFE_TX_TEST_TONE_EN
  localparam bit TONE_BUILD = 1'b1;
`else
  localparam bit TONE_BUILD = 1'b0;
`endif

  // clock / reset
  logic tx_sclk_2x = 1'b0;
  always #5 tx_sclk_2x = ~tx_sclk_2x;

  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [15:0]        cfg_burst_len = 16'd0;
  logic               cfg_test = 1'b0;
  logic               host_fifo_empty = 1'b1;
  logic [FIFO_AW-1:0] host_fifo_usedw = '0;
  logic [31:0]        host_fifo_data = 32'd0;
  logic               host_fifo_req;
  logic               afe_fifo_req = 1'b0;
  logic [31:0]        afe_fifo_data;
  logic               afe_fifo_empty;
  logic               tx_en;
  logic               busy;
  logic               done;
  logic [15:0]        underrun_cnt;
  logic [1:0]         dbg_state;

  afe_tx_burst_ctrl #(.FIFO_AW(FIFO_AW), .PREFILL_LVL(PREFILL_LVL), .DRAIN_CYC(DRAIN_CYC)) dut (
    .tx_sclk_2x(tx_sclk_2x), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_burst_len(cfg_burst_len),
`ifdef AFE_TX_TEST_TONE_EN
    .cfg_test(cfg_test),
`endif
    .host_fifo_empty(host_fifo_empty), .host_fifo_usedw(host_fifo_usedw),
    .host_fifo_data(host_fifo_data), .host_fifo_req(host_fifo_req),
    .afe_fifo_req(afe_fifo_req), .afe_fifo_data(afe_fifo_data),
    .afe_fifo_empty(afe_fifo_empty), .tx_en(tx_en), .busy(busy), .done(done),
    .underrun_cnt(underrun_cnt), .dbg_state(dbg_state)
  );

  // host FIFO contents (environment) and the model's own copy (scoreboard expected queue)
  logic [31:0] host_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  int n_cmp = 0, n_err = 0;
  int n_reads = 0, n_done = 0, cyc = 0, first_usedw = -1;
  int afe_mode = 0;
  bit rand_empty = 0, force_empty = 0, primed = 0;

  // burst-level model: 0 idle, 1 waiting for fill, 2 streaming, 3 tail
  int          m_phase = 0, m_rem = 0, m_drain = 0, m_ucnt = 0;
  bit          m_cont = 0, m_test = 0, m_done = 0;
  logic [31:0] m_data = 32'd0;
  logic [15:0] m_ramp = 16'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      host_q.push_back(32'(base + i));
      exp_q.push_back(32'(base + i));
    end
  endtask

  task automatic flush();
    host_q.delete(); exp_q.delete(); got_q.delete();
    n_reads = 0; n_done = 0; force_empty = 0; rand_empty = 0; first_usedw = -1;
  endtask

  // one clock: drive at negedge, sample just before posedge, compare after it
  task automatic tick();
    logic s_rst, s_start, s_stop, s_areq, s_empty, s_test, d_hreq, e_hreq, slot;
    int s_usedw;
    logic [15:0] s_len;
    cyc++;
    case (afe_mode)
      0: afe_fifo_req = cyc[0];
      1: afe_fifo_req = 1'b1;
      default: afe_fifo_req = 1'($urandom_range(0, 1));
    endcase
    if (rand_empty) force_empty = ($urandom_range(0, 7) == 0);
    host_fifo_empty = force_empty || (host_q.size() == 0);
    host_fifo_usedw = (host_q.size() > 511) ? 9'd511 : 9'(host_q.size());
    #4;
    s_rst = reset_n; s_start = start; s_stop = stop; s_areq = afe_fifo_req;
    s_empty = host_fifo_empty; s_usedw = int'(host_fifo_usedw); s_len = cfg_burst_len;
    s_test = cfg_test;
    slot   = (m_phase == 2) && s_areq && (m_cont || m_rem != 0);
    e_hreq = slot && !m_test && !s_empty;
    d_hreq = host_fifo_req;
    if (primed) check("host_fifo_req", 32'(d_hreq), 32'(e_hreq));
    @(posedge tx_sclk_2x);
    #1;
    if (d_hreq) begin
      n_reads++;
      if (first_usedw < 0) first_usedw = s_usedw;
      host_fifo_data = (host_q.size() != 0) ? host_q.pop_front() : 32'hDEADBEEF;
    end else begin
      host_fifo_data = $urandom;
    end
    #1;
    m_done = 0;
    m_data = 32'd0;
    if (!s_rst) begin
      m_phase = 0; m_ucnt = 0; m_rem = 0; m_drain = 0;
      if (e_hreq && exp_q.size() != 0) void'(exp_q.pop_front());
      primed = 1;
    end else begin
      case (m_phase)
        0: if (s_start) begin
          m_phase = 1; m_rem = int'(s_len); m_cont = (s_len == 16'd0);
          m_test = TONE_BUILD && s_test; m_ucnt = 0; m_ramp = 16'd0;
        end
        1: if (s_stop) begin
          m_phase = 3; m_drain = 0;
        end else if (m_test || s_usedw >= PREFILL_LVL || (!m_cont && s_usedw >= m_rem)) begin
          m_phase = 2;
        end
        2: begin
          if (slot && m_test) begin
            m_data = {m_ramp, ~m_ramp};
            m_ramp = m_ramp + 16'd1;
            if (!m_cont) m_rem--;
            got_q.push_back(afe_fifo_data);
          end else if (slot && !s_empty) begin
            m_data = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
            if (!m_cont) m_rem--;
            got_q.push_back(afe_fifo_data);
          end else if (slot) begin
            m_ucnt = (m_ucnt == 65535) ? 65535 : m_ucnt + 1;
          end
          if (s_stop || (!m_cont && m_rem == 0)) begin
            m_phase = 3; m_drain = 0;
          end
        end
        default: begin
          m_drain++;
          if (m_drain == DRAIN_CYC) begin
            m_phase = 0; m_done = 1;
          end
        end
      endcase
    end
    if (primed) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("tx_en", 32'(tx_en), 32'(m_phase != 0));
      check("afe_fifo_empty", 32'(afe_fifo_empty), 32'(m_phase == 0));
      check("done", 32'(done), 32'(m_done));
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
      check("afe_fifo_data", afe_fifo_data, m_data);
    end
    if (done) n_done++;
    @(negedge tx_sclk_2x);
  endtask

  task automatic start_burst(input int len, input bit test);
    cfg_burst_len = 16'(len);
    cfg_test = test;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while ((busy || m_phase != 0) && k < max) begin
      tick();
      k++;
    end
    if (k >= max) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int k;
    int len;
    // reset
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_afe_empty", 32'(afe_fifo_empty), 32'd1);
    check("rst_afe_data", afe_fifo_data, 32'd0);

    // fixed-length burst
    flush(); push_words(0, 128); afe_mode = 0;
    start_burst(100, 0);
    wait_idle("fixed", 1000);
    check("fixed_reads", 32'(n_reads), 32'd100);
    check("fixed_count", 32'(got_q.size()), 32'd100);
    foreach (got_q[i]) check("fixed_word", got_q[i], 32'(i));
    check("fixed_done", 32'(n_done), 32'd1);
    check("fixed_urun", 32'(underrun_cnt), 32'd0);

    // prefill hold while the host FIFO fills slowly
    flush(); afe_mode = 2;
    start_burst(0, 0);
    for (int p = 0; p < 140; p++) begin
      if (p % 2 == 0 && p / 2 < 70) push_words(1000 + p / 2, 1);
      if (p == 118) check("prefill_hold_reads", 32'(n_reads), 32'd0);
      tick();
    end
    check("prefill_first_lvl", 32'(first_usedw >= PREFILL_LVL), 32'd1);
    pulse_stop();
    wait_idle("prefill", 200);
    foreach (got_q[i]) check("prefill_word", got_q[i], 32'(1000 + i));

    // underrun in a continuous burst
    flush(); push_words(2000, 80); afe_mode = 1;
    start_burst(0, 0);
    k = 0;
    while (n_reads < 20 && k < 200) begin tick(); k++; end
    if (k >= 200) check("urun_timeout", 32'd1, 32'd0);
    force_empty = 1;
    repeat (5) tick();
    force_empty = 0;
    repeat (10) tick();
    check("urun_cnt", 32'(underrun_cnt), 32'd5);
    pulse_stop();
    wait_idle("urun", 200);
    check("urun_done", 32'(n_done), 32'd1);
    foreach (got_q[i]) check("urun_word", got_q[i], 32'(2000 + i));

    // stop coincident with the final read
    flush(); push_words(3000, 20); afe_mode = 1;
    start_burst(10, 0);
    k = 0;
    while (!(m_phase == 2 && m_rem == 1) && k < 200) begin tick(); k++; end
    if (k >= 200) check("laststop_timeout", 32'd1, 32'd0);
    pulse_stop();
    wait_idle("laststop", 200);
    check("laststop_reads", 32'(n_reads), 32'd10);
    check("laststop_done", 32'(n_done), 32'd1);

    // reset in the middle of a run, then a clean burst
    flush(); push_words(4000, 128); afe_mode = 0;
    start_burst(100, 0);
    k = 0;
    while (n_reads < 37 && k < 400) begin tick(); k++; end
    if (k >= 400) check("midrst_timeout", 32'd1, 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_afe_empty", 32'(afe_fifo_empty), 32'd1);
    check("midrst_urun", 32'(underrun_cnt), 32'd0);
    flush(); push_words(5000, 20);
    start_burst(5, 0);
    wait_idle("after_rst", 300);
    check("after_rst_reads", 32'(n_reads), 32'd5);
    foreach (got_q[i]) check("after_rst_word", got_q[i], 32'(5000 + i));

    // randomized bursts
    for (int b = 0; b < 8; b++) begin
      flush(); afe_mode = 2; rand_empty = 1;
      push_words(6000 + b * 256, $urandom_range(0, 90));
      len = $urandom_range(0, 40);
      start_burst(len, 0);
      for (int c = 0; c < 250 && m_phase != 0; c++) begin
        if ($urandom_range(0, 3) == 0) push_words(6200 + b * 256 + c, 1);
        stop = ($urandom_range(0, 59) == 0);
        tick();
      end
      stop = 1'b0;
      pulse_stop();
      wait_idle("rand", 300);
    end
    rand_empty = 0; force_empty = 0;

`ifdef AFE_TX_TEST_TONE_EN
    flush(); afe_mode = 1;
    start_burst(3, 1);
    wait_idle("tone", 200);
    cfg_test = 1'b0;
    check("tone_reads", 32'(n_reads), 32'd0);
    check("tone_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("tone_w0", got_q[0], 32'h0000FFFF);
      check("tone_w1", got_q[1], 32'h0001FFFE);
      check("tone_w2", got_q[2], 32'h0002FFFD);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
